imm_ext_pipe: RTL and testbench

//  Parametrised, pipelined immediate extender with valid/ready handshake, the successor to the fixed 15->32 sign extender.

---
 rtl/imm_ext_pkg.sv | 58 +++++
 rtl/imm_ext_if.sv | 27 ++
 rtl/ext_skid_buf.sv | 99 +++++++++
 rtl/imm_ext_pipe.sv | 51 +++++
 tb/tb_imm_ext_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types and the combinational extension function for the immediate
// extender pipeline.
//   ext_mode_e   : extension mode carried alongside each raw immediate
//   skid_state_e : occupancy of the 2-entry output buffer
//   ext_calc()   : width-generic extension, evaluated on a MAX_W-bit canvas
package imm_ext_pkg;

    // Widest operand the extension function can produce.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_SIGN      = 2'd0,
        MODE_ZERO      = 2'd1,
        MODE_SIGN_SHL2 = 2'd2,
        MODE_UPPER     = 2'd3
    } ext_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // imm holds the raw field in its low in_w bits (upper bits ignored).
    // The result is valid in its low out_w bits; everything above is zero.
    function automatic logic [MAX_W-1:0] ext_calc(
        input logic [MAX_W-1:0] imm,
        input ext_mode_e        mode,
        input int               in_w,
        input int               out_w,
        input int               upper_sh
    );
        logic [MAX_W-1:0] in_mask;
        logic [MAX_W-1:0] out_mask;
        logic [MAX_W-1:0] zext;
        logic [MAX_W-1:0] sext;
        logic [MAX_W-1:0] res;
        logic [5:0]       sign_idx;
        logic             sign;
        // A shift by the full canvas width yields zero, so out_w == MAX_W
        // still produces an all-ones mask after the decrement.
        in_mask  = (MAX_W'(1) << in_w) - MAX_W'(1);
        out_mask = (MAX_W'(1) << out_w) - MAX_W'(1);
        sign_idx = 6'(in_w - 1);
        sign     = imm[sign_idx];
        zext     = imm & in_mask;
        sext     = sign ? (zext | ~in_mask) : zext;
        case (mode)
            MODE_SIGN:      res = sext;
            MODE_ZERO:      res = zext;
            MODE_SIGN_SHL2: res = sext << 2;
            MODE_UPPER:     res = zext << upper_sh;
            default:        res = '0;
        endcase
        return res & out_mask;
    endfunction

endpackage

// File: rtl/imm_ext_if.sv
// Handshake bundle between decode (producer), the extender and the ALU
// operand mux (consumer).
//   in_valid/in_ready/in_imm/in_mode : input side
//   out_valid/out_ready/out_data     : output side
// Modports: slave = the extender, master = the surrounding producer/consumer.
interface imm_ext_if #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ext_skid_buf.sv
// Generic 2-entry valid/ready buffer with fully registered outputs.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake, in_data captured on acceptance
//   out_valid/out_ready   output handshake, out_data is the head entry
//   busy                  at least one entry held
//
// state | meaning
// EMPTY | nothing held, accepting
// ONE   | head entry in main, accepting
// TWO   | head in main, next in skid, not accepting
module ext_skid_buf
    import imm_ext_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic         acc;
    logic         pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (acc && !pop) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (acc && pop) begin
                    main_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are registered copies of the next-state decode,
        // so neither depends combinationally on the opposite handshake.
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
        busy_d      = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign busy      = busy_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender between decode and the ALU operand mux.
// The immediate is extended combinationally on entry and stored already
// extended in a 2-entry skid buffer, giving one-cycle latency when empty
// and one result per clock at full rate.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          handshake bundle (slave side): in_* from decode, out_* to ALU
//   busy         at least one extended operand held
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = 15,
    parameter int OUT_W    = 32,
    parameter int UPPER_SH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    imm_ext_if.slave   bus,
    output logic       busy
);

    if (IN_W < 1 || IN_W >= OUT_W || UPPER_SH < 0 || UPPER_SH >= OUT_W ||
        OUT_W > MAX_W) begin : g_bad_params
        $error("imm_ext_pipe: illegal IN_W/OUT_W/UPPER_SH combination");
    end

    logic [MAX_W-1:0] imm_pad;
    ext_mode_e        mode;
    logic [OUT_W-1:0] ext_data;

    assign imm_pad  = {{(MAX_W-IN_W){1'b0}}, bus.in_imm};
    assign mode     = ext_mode_e'(bus.in_mode);
    // Only captured on acceptance, so garbage on idle cycles never lands
    // in a register.
    assign ext_data = OUT_W'(ext_calc(imm_pad, mode, IN_W, OUT_W, UPPER_SH));

    ext_skid_buf #(
        .W (OUT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (ext_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .busy      (busy)
    );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe (IN_W=15, OUT_W=32, UPPER_SH=16).
module tb_imm_ext_pipe;

    logic clk;
    logic rst_n;
    logic busy;
    int   tests_run;
    int   tests_failed;

    imm_ext_if #(.IN_W(15), .OUT_W(32)) bus ();

    imm_ext_pipe #(
        .IN_W     (15),
        .OUT_W    (32),
        .UPPER_SH (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed value of the field as an integer, then plain arithmetic.
    function automatic logic [31:0] ref_ext(input logic [14:0] imm, input logic [1:0] mode);
        int sv;
        int uv;
        uv = int'(imm);
        sv = imm[14] ? uv - 32768 : uv;
        case (mode)
            2'd0:    return 32'(sv);
            2'd1:    return 32'(uv);
            2'd2:    return 32'(sv * 4);
            default: return 32'(uv * 65536);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 00000000",
                     bus.in_ready, bus.out_valid, busy, bus.out_data);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'd0;
        bus.in_imm    = 15'h0AA;
        step();
        bus.in_imm    = 15'h0BB;
        step();
        bus.in_valid  = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fill: busy=%b in_ready=%b, want 1 0", busy, bus.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_async: out_valid=%b busy=%b in_ready=%b out_data=%h, want 0 0 1 00000000",
                     bus.out_valid, busy, bus.in_ready, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b1;
        bus.in_mode  = 2'd1;
        bus.in_imm   = 15'h123;
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_0123) begin
            tests_failed++;
            $display("FAIL reset_first_accept: out_valid=%b out_data=%h, want 1 00000123",
                     bus.out_valid, bus.out_data);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_stale: out_valid=%b busy=%b, want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_modes();
        logic [14:0] imms [4];
        logic [1:0]  modes[4];
        logic [31:0] exps [4];
        imms  = '{15'h4000, 15'h4000, 15'h7FFF, 15'h1234};
        modes = '{2'd0, 2'd1, 2'd2, 2'd3};
        exps  = '{32'hFFFF_C000, 32'h0000_4000, 32'hFFFF_FFFC, 32'h1234_0000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = imms[i];
            bus.in_mode  = modes[i];
            step();
            bus.in_valid = 1'b0;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i]) begin
                tests_failed++;
                $display("FAIL mode_%0d: out_valid=%b out_data=%h, want 1 %h",
                         i, bus.out_valid, bus.out_data, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'd0;
        bus.in_imm    = 15'd1;
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_first: out_valid=%b out_data=%h in_ready=%b, want 1 1 1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        bus.in_imm = 15'd2;
        step();
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: in_ready=%b, want 0", bus.in_ready);
        end
        bus.in_imm = 15'd3;
        step();
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'd1) begin
            tests_failed++;
            $display("FAIL bp_hold_off: in_ready=%b out_data=%h, want 0 1", bus.in_ready, bus.out_data);
        end
        bus.out_ready = 1'b1;
        step();
        tests_run++;
        if (bus.out_data !== 32'd2 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_second: out_data=%h in_ready=%b, want 2 1", bus.out_data, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd3) begin
            tests_failed++;
            $display("FAIL bp_third: out_valid=%b out_data=%h, want 1 3", bus.out_valid, bus.out_data);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_throughput();
        logic [31:0] q[$];
        logic [31:0] exp;
        int          sent;
        int          outs;
        bit          acc;
        sent = 0;
        outs = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 15'($urandom);
        bus.in_mode   = 2'($urandom_range(0, 3));
        for (int cyc = 1; cyc <= 101; cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.in_valid) begin
                tests_run++;
                if (bus.in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL tput_stall: cycle %0d in_ready=%b, want 1", cyc, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : 32'hxxxx_xxxx;
                tests_run++;
                if (bus.out_data !== exp) begin
                    tests_failed++;
                    $display("FAIL tput_data: output %0d out_data=%h, want %h", outs, bus.out_data, exp);
                end
                outs++;
            end
            if (acc) begin
                q.push_back(ref_ext(bus.in_imm, bus.in_mode));
                sent++;
            end
            step();
            if (acc) begin
                if (sent < 100) begin
                    bus.in_imm  = 15'($urandom);
                    bus.in_mode = 2'($urandom_range(0, 3));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        tests_run++;
        if (outs != 100 || sent != 100) begin
            tests_failed++;
            $display("FAIL tput_count: %0d outputs from %0d inputs in 101 cycles, want 100 from 100",
                     outs, sent);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tput_empty: out_valid=%b, want 0", bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_stall_hold();
        logic [31:0] exp;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 15'($urandom);
        bus.in_mode   = 2'($urandom_range(0, 3));
        exp = ref_ext(bus.in_imm, bus.in_mode);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d out_valid=%b out_data=%h, want 1 %h",
                         i, bus.out_valid, bus.out_data, exp);
            end
            bus.in_mode = ~bus.in_mode;
            bus.in_imm  = 15'($urandom);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp;
        int          sent;
        int          outs;
        int          cyc;
        bit          acc;
        sent = 0;
        outs = 0;
        cyc  = 0;
        bus.in_valid  = 1'($urandom);
        bus.in_imm    = 15'($urandom);
        bus.in_mode   = 2'($urandom);
        bus.out_ready = 1'($urandom);
        while (outs < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            tests_run++;
            if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() != 0)) begin
                tests_failed++;
                $display("FAIL rand_occupancy: cycle %0d held=%0d in_ready=%b out_valid=%b",
                         cyc, q.size(), bus.in_ready, bus.out_valid);
            end
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : 32'hxxxx_xxxx;
                tests_run++;
                if (bus.out_data !== exp) begin
                    tests_failed++;
                    $display("FAIL rand_data: output %0d out_data=%h, want %h", outs, bus.out_data, exp);
                end
                outs++;
            end
            if (acc) begin
                q.push_back(ref_ext(bus.in_imm, bus.in_mode));
                sent++;
            end
            step();
            // A refused offer must be held unchanged until it is taken.
            if (!bus.in_valid || acc) begin
                bus.in_valid = (sent < 10000) ? 1'($urandom) : 1'b0;
                bus.in_imm   = 15'($urandom);
                bus.in_mode  = 2'($urandom);
            end
            bus.out_ready = 1'($urandom);
        end
        tests_run++;
        if (outs != 10000 || sent != 10000 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_count: %0d in, %0d out, %0d left after %0d cycles, want 10000 10000 0",
                     sent, outs, q.size(), cyc);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_reset();
        test_modes();
        test_back_pressure();
        test_throughput();
        test_stall_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
